// File: rtl/iot_event_sequencer_pkg.sv
// Shared constants and helpers for the IoT event sequencer: direction encodings,
// default counter width and a 16-bit population count.
package iot_pkg;

    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
    localparam int   CNT_W_DEFAULT = 8;

    // Callers zero-extend their device vector to 16 bits (N_DEV is at most 16).
    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/iot_event_sequencer_if.sv
// Device-activity inputs and monitor-facing outputs of the event sequencer.
// master = the side driving devices/enable, slave = the sequencer.
interface iot_event_sequencer_if #(
    parameter int N_DEV = 8,
    parameter int CNT_W = 8
);
    logic [N_DEV-1:0] dev_active;
    logic             en;
    logic             on_off;
    logic             change;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] shadow_count;
    logic             overflow;

    modport master (
        output dev_active, en,
        input  on_off, change, pending, shadow_count, overflow
    );

    modport slave (
        input  dev_active, en,
        output on_off, change, pending, shadow_count, overflow
    );
endinterface

// File: rtl/iot_event_sequencer_edge_detect.sv
// Registers the previous device-activity vector and flags connect (rise) and
// disconnect (fall) edges combinationally against the current inputs.
module iot_edge_detect #(
    parameter int N_DEV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_active,
    output logic [N_DEV-1:0] rise,
    output logic [N_DEV-1:0] fall
);

    logic [N_DEV-1:0] prev_active_q;
    logic [N_DEV-1:0] prev_active_d;

    always_comb begin
        prev_active_d = dev_active;
        rise          = dev_active & ~prev_active_q;
        fall          = ~dev_active & prev_active_q;
    end

    // Clearing to zero makes devices already high after reset announce as rises.
    always_ff @(posedge clk) begin
        if (rst) prev_active_q <= '0;
        else     prev_active_q <= prev_active_d;
    end

endmodule

// File: rtl/iot_event_sequencer.sv
// Queues device connect/disconnect events and replays them to the active-device
// monitor one per clock, keeping a shadow of the count the monitor should hold.
module iot_event_sequencer
    import iot_pkg::*;
#(
    parameter int N_DEV = 8,
    parameter int CNT_W = iot_pkg::CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    iot_event_sequencer_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_DEV-1:0] rise;
    logic [N_DEV-1:0] fall;
    logic [15:0]      rise_ext;
    logic [15:0]      fall_ext;

    logic [CNT_W-1:0] pending_up_q,   pending_up_d;
    logic [CNT_W-1:0] pending_down_q, pending_down_d;
    logic [CNT_W-1:0] shadow_count_q, shadow_count_d;
    logic             on_off_q,       on_off_d;
    logic             change_q,       change_d;
    logic             overflow_q,     overflow_d;

    logic             emit_up;
    logic             emit_down;
    logic [CNT_W:0]   up_sum;
    logic [CNT_W:0]   down_sum;
    logic [CNT_W:0]   pending_sum;

    iot_edge_detect #(.N_DEV(N_DEV)) u_edge_detect (
        .clk        (clk),
        .rst        (rst),
        .dev_active (bus.dev_active),
        .rise       (rise),
        .fall       (fall)
    );

    always_comb begin
        rise_ext             = '0;
        fall_ext             = '0;
        rise_ext[N_DEV-1:0]  = rise;
        fall_ext[N_DEV-1:0]  = fall;

        // Up has priority so the monitor never sees a decrement below zero.
        emit_up   = bus.en && (pending_up_q != '0);
        emit_down = bus.en && (pending_up_q == '0) && (pending_down_q != '0);

        // A decrement only happens on a non-zero counter, so the sums cannot underflow.
        up_sum   = {1'b0, pending_up_q}   + (CNT_W+1)'(popcount(rise_ext)) - (CNT_W+1)'(emit_up);
        down_sum = {1'b0, pending_down_q} + (CNT_W+1)'(popcount(fall_ext)) - (CNT_W+1)'(emit_down);

        pending_up_d   = up_sum[CNT_W]   ? CNT_MAX : up_sum[CNT_W-1:0];
        pending_down_d = down_sum[CNT_W] ? CNT_MAX : down_sum[CNT_W-1:0];
        overflow_d     = overflow_q | up_sum[CNT_W] | down_sum[CNT_W];

        on_off_d       = emit_up | emit_down;
        change_d       = emit_down ? DIR_DOWN : DIR_UP;
        shadow_count_d = shadow_count_q;
        if (emit_up)        shadow_count_d = shadow_count_q + 1'b1;
        else if (emit_down) shadow_count_d = shadow_count_q - 1'b1;

        pending_sum = {1'b0, pending_up_q} + {1'b0, pending_down_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_up_q   <= '0;
            pending_down_q <= '0;
            shadow_count_q <= '0;
            on_off_q       <= 1'b0;
            change_q       <= DIR_UP;
            overflow_q     <= 1'b0;
        end else begin
            pending_up_q   <= pending_up_d;
            pending_down_q <= pending_down_d;
            shadow_count_q <= shadow_count_d;
            on_off_q       <= on_off_d;
            change_q       <= change_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.on_off       = on_off_q;
    assign bus.change       = change_q;
    assign bus.shadow_count = shadow_count_q;
    assign bus.overflow     = overflow_q;
    assign bus.pending      = pending_sum[CNT_W] ? CNT_MAX : pending_sum[CNT_W-1:0];

endmodule

// File: tb/tb_iot_event_sequencer.sv
// Directed self-checking bench for iot_event_sequencer with hand-computed
// pulse sequences, stall, saturation and reset-mid-burst cases.
module tb_iot_event_sequencer;

    logic clk;
    logic rst;

    iot_event_sequencer_if #(.N_DEV(8), .CNT_W(8)) bus ();

    iot_event_sequencer #(.N_DEV(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_shadow = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call right after changing dev_active with en=1 and nothing pending:
    // capture edge, then n_up up pulses, n_dn down pulses, then idle.
    task automatic expect_burst(input string tag, input int n_up, input int n_dn);
        step();
        check_eq({tag, " capture on_off"}, 32'(bus.on_off), 0);
        check_eq({tag, " capture pending"}, 32'(bus.pending), 32'(n_up + n_dn));
        for (int i = 0; i < n_up + n_dn; i++) begin
            step();
            exp_shadow = (i < n_up) ? (exp_shadow + 1) & 255 : (exp_shadow - 1) & 255;
            check_eq($sformatf("%s pulse%0d on_off", tag, i), 32'(bus.on_off), 1);
            check_eq($sformatf("%s pulse%0d change", tag, i), 32'(bus.change), (i < n_up) ? 1 : 0);
            check_eq($sformatf("%s pulse%0d shadow", tag, i), 32'(bus.shadow_count), 32'(exp_shadow));
        end
        step();
        check_eq({tag, " idle on_off"}, 32'(bus.on_off), 0);
        check_eq({tag, " idle change"}, 32'(bus.change), 1);
        check_eq({tag, " idle pending"}, 32'(bus.pending), 0);
        check_eq({tag, " idle shadow"}, 32'(bus.shadow_count), 32'(exp_shadow));
    endtask

    initial begin
        int bad;
        rst            = 1'b1;
        bus.dev_active = 8'hFF;
        bus.en         = 1'b1;

        // Reset hold
        repeat (3) step();
        check_eq("rst on_off",   32'(bus.on_off), 0);
        check_eq("rst change",   32'(bus.change), 1);
        check_eq("rst shadow",   32'(bus.shadow_count), 0);
        check_eq("rst pending",  32'(bus.pending), 0);
        check_eq("rst overflow", 32'(bus.overflow), 0);
        rst = 1'b0;
        expect_burst("rst_release", 8, 0);

        // Single connect / disconnect
        bus.dev_active = 8'h00;
        expect_burst("all_down", 0, 8);
        bus.dev_active = 8'h01;
        expect_burst("connect", 1, 0);
        bus.dev_active = 8'h00;
        expect_burst("disconnect", 0, 1);

        // Mixed same-cycle rises and falls
        bus.dev_active = 8'h0C;
        expect_burst("mixed_pre", 2, 0);
        bus.dev_active = 8'h03;
        expect_burst("mixed", 2, 2);

        // Stall with en=0
        bus.en = 1'b0;
        bus.dev_active = 8'h1F;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall%0d on_off", i), 32'(bus.on_off), 0);
            check_eq($sformatf("stall%0d pending", i), 32'(bus.pending), 3);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_shadow++;
            check_eq($sformatf("resume%0d on_off", i), 32'(bus.on_off), 1);
            check_eq($sformatf("resume%0d change", i), 32'(bus.change), 1);
            check_eq($sformatf("resume%0d shadow", i), 32'(bus.shadow_count), 32'(exp_shadow));
        end
        step();
        check_eq("resume idle on_off", 32'(bus.on_off), 0);
        check_eq("resume idle pending", 32'(bus.pending), 0);
        check_eq("pre-ovf overflow", 32'(bus.overflow), 0);

        // Overflow: 300 falls and 300 rises on device 0 while stalled
        bus.en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus.dev_active[0] = ~bus.dev_active[0];
            step();
        end
        check_eq("ovf pending",  32'(bus.pending), 255);
        check_eq("ovf overflow", 32'(bus.overflow), 1);
        check_eq("ovf on_off",   32'(bus.on_off), 0);
        bus.en = 1'b1;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            if (bus.on_off !== 1'b1 || bus.change !== 1'b1) bad++;
        end
        exp_shadow = (exp_shadow + 255) & 255;
        check_eq("ovf up drain bad pulses", 32'(bad), 0);
        check_eq("ovf down saturated", 32'(bus.pending), 255);
        check_eq("ovf shadow wrap", 32'(bus.shadow_count), 32'(exp_shadow));
        check_eq("ovf sticky", 32'(bus.overflow), 1);
        step();
        exp_shadow = (exp_shadow - 1) & 255;
        check_eq("ovf down on_off", 32'(bus.on_off), 1);
        check_eq("ovf down change", 32'(bus.change), 0);
        check_eq("ovf down shadow", 32'(bus.shadow_count), 32'(exp_shadow));
        check_eq("ovf down pending", 32'(bus.pending), 254);

        // Reset clears overflow and everything else
        rst = 1'b1;
        bus.dev_active = 8'h00;
        step();
        check_eq("rst2 overflow", 32'(bus.overflow), 0);
        check_eq("rst2 pending",  32'(bus.pending), 0);
        check_eq("rst2 shadow",   32'(bus.shadow_count), 0);
        check_eq("rst2 on_off",   32'(bus.on_off), 0);
        rst = 1'b0;
        exp_shadow = 0;

        // Reset mid-burst
        bus.dev_active = 8'h0F;
        step();
        check_eq("mid capture pending", 32'(bus.pending), 4);
        step();
        check_eq("mid pulse0 on_off", 32'(bus.on_off), 1);
        step();
        check_eq("mid pulse1 on_off", 32'(bus.on_off), 1);
        check_eq("mid pulse1 shadow", 32'(bus.shadow_count), 2);
        rst = 1'b1;
        step();
        check_eq("mid rst on_off",  32'(bus.on_off), 0);
        check_eq("mid rst shadow",  32'(bus.shadow_count), 0);
        check_eq("mid rst pending", 32'(bus.pending), 0);
        bus.dev_active = 8'h03;
        step();
        check_eq("mid rst2 on_off", 32'(bus.on_off), 0);
        rst = 1'b0;
        expect_burst("mid reannounce", 2, 0);
        step();
        check_eq("final on_off", 32'(bus.on_off), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iot_event_sequencer.md
Name: iot_event_sequencer

Overview:
- Transmit-side companion to the active-IoT-devices monitor.
- Watches N device-activity lines and detects connect (rise) and disconnect (fall) edges.
- Queues those events and drives the monitor's on_off (enable pulse) and change (direction: 1=up, 0=down) inputs, one event per clock.
- Keeps a shadow copy of the count the monitor should hold, so verification can compare the two directly.

Parameters:
- N_DEV, 8, number of device activity inputs (1..16).
- CNT_W, 8, width of pending counters and shadow count; matches the monitor counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- dev_active  input  N_DEV  per-device active level; already synchronous to clk.
- en  input  1  emission enable; 0 stalls output, but edges are still captured.
- on_off  output  1  one-cycle pulse per emitted event, to monitor on_off.
- change  output  1  direction of the current pulse, to monitor change.
- pending  output  CNT_W  pending_up + pending_down, saturated at all-ones.
- shadow_count  output  CNT_W  expected monitor count after all emitted events.
- overflow  output  1  sticky; set when a pending counter saturates.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - prev_active=0, pending_up=0, pending_down=0.
  - on_off=0, change=1, shadow_count=0, overflow=0.
  - rst overrides every other input on that edge.
- Edge detect, combinational on the current inputs:
  - rise = dev_active & ~prev_active
  - fall = ~dev_active & prev_active
  - prev_active <= dev_active on every non-reset edge.
  - Devices already high on the first cycle after reset produce rise events.
- Counter update at each edge:
  - pending_up <= pending_up + popcount(rise) - emit_up
  - pending_down <= pending_down + popcount(fall) - emit_down
  - Each sum is computed at CNT_W+1 bits and saturates at 2^CNT_W-1.
  - Saturation, meaning any dropped increment, sets overflow. It clears only on rst.
- Emission decision uses the registered pending values from before this edge:
  - emit_up = en & (pending_up != 0)
  - emit_down = en & (pending_up == 0) & (pending_down != 0)
  - Up has priority, so the monitor never counts below zero in legal use.
- Registered outputs at the same edge:
  - on_off <= emit_up | emit_down
  - change <= 1 if emit_up; 0 if emit_down; 1 when idle.
  - shadow_count <= shadow_count + 1 on emit_up, - 1 on emit_down, mod 2^CNT_W (wraps like the monitor).
- Latency:
  - dev_active changes before edge k, so pending updates at edge k.
  - on_off is high from edge k+1 to edge k+2.
  - Back-to-back events produce consecutive one-cycle pulses with no gap.
- Simultaneous events:
  - Rise and fall on different devices in the same cycle: both counted; the up is emitted first.
  - A device toggling every cycle generates one event per edge.
- en=0: on_off=0, change=1, pending keeps accumulating. Emission resumes on the first edge with en=1.
- pending output is a combinational saturating sum of the two registers.

Decomposition:
- Package iot_pkg holds:
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - CNT_W default 8.
  - Function popcount over N_DEV bits.
- Sub-module iot_edge_detect (prev_active register plus rise/fall vectors), instantiated once.
- The top holds the pending counters, arbiter and output registers.

Test Plan:
- Reset hold:
  - Stimulus: rst=1 for 3 cycles with dev_active=8'hFF.
  - Required: on_off=0, change=1, shadow_count=0, pending=0, overflow=0.
  - Then rst=0: 8 consecutive up pulses start 2 edges later, ending with shadow_count=8.
- Single connect:
  - Stimulus: dev_active 0 -> 8'h01 before edge k, en=1.
  - Required: on_off=1 and change=1 during cycle k+1 only; shadow_count=1.
  - Then 8'h01 -> 0: one pulse with change=0; shadow_count=0.
- Mixed same-cycle:
  - Stimulus: dev_active 8'h0C -> 8'h03 (2 rises, 2 falls).
  - Required: pulses change=1,1,0,0 on consecutive cycles; shadow_count goes from 2 back to 2; pending reaches 0.
- Stall:
  - Stimulus: en=0 while 3 rises occur.
  - Required: on_off stays 0 and pending=3.
  - After en=1: 3 up pulses, then pending=0.
- Overflow:
  - Stimulus: en=0, device 0 toggled 600 times.
  - Required: pending_up and pending_down each saturate at 255; overflow=1 and stays 1 until rst.
- Reset mid-burst:
  - Stimulus: assert rst during the 2nd of 4 pending pulses.
  - Required: on_off=0 and all counts 0 from the next edge on; no further pulses for devices that were already active before reset.
  - Exception: devices still high after rst drops re-announce as rises.
